load_store_unit: RTL and testbench

Memory-access stage of the RV32I core. It accepts one load or store per transaction from execute and drives a req/gnt/rvalid data-memory bus. It aligns store data into byte lanes and extracts and sign/zero-extends load data. The registered load result feeds the write-back select as its data-memory input.

---
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: one load/store per transaction over a req/gnt/rvalid bus,
// with store lane alignment, load extraction and a bus-timeout guard.
module load_store_unit #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_lsu_valid,
  output logic                 o_lsu_ready,
  input  logic                 i_is_load,
  input  logic                 i_is_store,
  input  logic [2:0]           i_funct3,
  input  logic [DataWidth-1:0] i_addr,
  input  logic [DataWidth-1:0] i_store_data,
  output logic                 o_mem_req,
  input  logic                 i_mem_gnt,
  output logic                 o_mem_we,
  output logic [DataWidth-1:0] o_mem_addr,
  output logic [DataWidth-1:0] o_mem_wdata,
  output logic [3:0]           o_mem_wmask,
  input  logic                 i_mem_rvalid,
  input  logic [DataWidth-1:0] i_mem_rdata,
  output logic [DataWidth-1:0] o_data_mem_out,
  output logic                 o_done,
  output logic                 o_fault,
  output logic                 o_bus_error,
  output logic                 o_stall
);

  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                 r_state, w_state_next;
  logic                   r_is_load;
  logic [2:0]             r_funct3;
  logic [DataWidth-1:0]   r_addr;
  logic [DataWidth-1:0]   r_sdata;
  logic [CntW-1:0]        r_cnt;
  logic                   r_fault;
  logic                   r_bus_err;
  logic [DataWidth-1:0]   r_dout;

  logic                   w_accept;
  logic                   w_f3_ok;
  logic                   w_misal;
  logic                   w_fault;
  logic                   w_expired;
  logic                   w_timeout;
  logic                   w_load_done;
  logic [7:0]             w_byte;
  logic [15:0]            w_half;
  logic [DataWidth-1:0]   w_load_data;

  assign w_accept = (r_state == StIdle) && i_lsu_valid && (i_is_load ^ i_is_store);

  always_comb begin
    w_f3_ok = 1'b0;
    if (i_is_store) begin
      w_f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
    end else begin
      w_f3_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
    end
  end

  assign w_misal = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  assign w_fault = !w_f3_ok || w_misal;

  // A grant in the last allowed cycle still counts as progress, so it beats the timeout.
  assign w_expired   = (r_cnt >= CntLast);
  assign w_timeout   = w_expired && (((r_state == StReq) && !i_mem_gnt) ||
                                     ((r_state == StWait) && !i_mem_rvalid));
  assign w_load_done = (r_state == StWait) && i_mem_rvalid;

  always_comb begin
    w_byte = 8'h00;
    unique case (r_addr[1:0])
      2'b00: w_byte = i_mem_rdata[7:0];
      2'b01: w_byte = i_mem_rdata[15:8];
      2'b10: w_byte = i_mem_rdata[23:16];
      2'b11: w_byte = i_mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'h000000, w_byte};
      3'b101:  w_load_data = {16'h0000, w_half};
      default: w_load_data = i_mem_rdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = w_fault ? StDone : StReq;
      end
      StReq: begin
        if (i_mem_gnt)      w_state_next = r_is_load ? StWait : StDone;
        else if (w_timeout) w_state_next = StDone;
      end
      StWait: begin
        if (w_load_done || w_timeout) w_state_next = StDone;
      end
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_is_load <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr    <= '0;
      r_sdata   <= '0;
      r_cnt     <= '0;
      r_fault   <= 1'b0;
      r_bus_err <= 1'b0;
      r_dout    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_is_load <= i_is_load;
        r_funct3  <= i_funct3;
        r_addr    <= i_addr;
        r_sdata   <= i_store_data;
        r_cnt     <= '0;
        r_fault   <= w_fault;
        r_bus_err <= 1'b0;
      end else if ((r_state == StReq) || (r_state == StWait)) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
        r_dout    <= '0;
      end else if (w_load_done) begin
        r_dout <= w_load_data;
      end
    end
  end

  always_comb begin
    o_mem_wmask = 4'b0000;
    o_mem_wdata = r_sdata;
    case (r_funct3[1:0])
      2'b00: begin
        o_mem_wmask = 4'b0001 << r_addr[1:0];
        o_mem_wdata = {4{r_sdata[7:0]}};
      end
      2'b01: begin
        o_mem_wmask = 4'b0011 << r_addr[1:0];
        o_mem_wdata = {2{r_sdata[15:0]}};
      end
      default: o_mem_wmask = 4'b1111;
    endcase
    if ((r_state != StReq) || r_is_load) o_mem_wmask = 4'b0000;
  end

  assign o_mem_req      = (r_state == StReq);
  assign o_mem_we       = (r_state == StReq) && !r_is_load;
  assign o_mem_addr     = {r_addr[DataWidth-1:2], 2'b00};
  assign o_data_mem_out = r_dout;
  assign o_done         = (r_state == StDone);
  assign o_fault        = (r_state == StDone) && r_fault;
  assign o_bus_error    = (r_state == StDone) && r_bus_err;
  assign o_stall        = (r_state == StReq) || (r_state == StWait);
  assign o_lsu_ready    = (r_state == StIdle);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: table of ops with a bus responder, plus reset and
// invalid-op sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid, lsu_ready, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, data_mem_out;
  logic [3:0]  mem_wmask;
  logic        done, fault, bus_error, stall;

  always #5 clk = ~clk;

  load_store_unit #(.DataWidth(32), .TimeoutCycles(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready),
    .i_is_load(is_load), .i_is_store(is_store), .i_funct3(funct3), .i_addr(addr),
    .i_store_data(store_data), .o_mem_req(mem_req), .i_mem_gnt(mem_gnt), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_data_mem_out(data_mem_out),
    .o_done(done), .o_fault(fault), .o_bus_error(bus_error), .o_stall(stall)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    int          gnt_dly;
    logic        rv;
    logic [31:0] rdata;
    int          lat;
    logic        flt;
    logic        be;
    logic        req;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] dout;
    logic [31:0] maddr;
  } vec_t;

  localparam int NumVec = 17;
  vec_t vecs[NumVec];
  vec_t v;

  int          cyc, req_cycles, lat;
  logic        got_done, stable_bad, stall_bad, got_flt, got_be;
  logic [31:0] got_dout, cap_addr, cap_wdata;
  logic        cap_we;
  logic [3:0]  cap_mask;

  initial begin
    //          ld st f3      addr          sd            dly rv rdata         lat flt be req we mask  wdata         dout          maddr
    vecs[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,        0, 1, 32'hDEADBEEF, 3, 0, 0, 1, 0, 4'h0, 32'h0,        32'hDEADBEEF, 32'h100};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        0, 1, 32'h80112233, 3, 0, 0, 1, 0, 4'h0, 32'h0,        32'hFFFFFF80, 32'h100};
    vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        0, 1, 32'h80112233, 3, 0, 0, 1, 0, 4'h0, 32'h0,        32'h00000080, 32'h100};
    vecs[3]  = '{1, 0, 3'b001, 32'h102, 32'h0,        0, 1, 32'h80112233, 3, 0, 0, 1, 0, 4'h0, 32'h0,        32'hFFFF8011, 32'h100};
    vecs[4]  = '{1, 0, 3'b101, 32'h100, 32'h0,        0, 1, 32'h80112233, 3, 0, 0, 1, 0, 4'h0, 32'h0,        32'h00002233, 32'h100};
    vecs[5]  = '{0, 1, 3'b000, 32'h201, 32'hA5,       3, 0, 32'h0,        5, 0, 0, 1, 1, 4'h2, 32'hA5A5A5A5, 32'h00002233, 32'h200};
    vecs[6]  = '{0, 1, 3'b001, 32'h202, 32'h1234BEEF, 0, 0, 32'h0,        2, 0, 0, 1, 1, 4'hC, 32'hBEEFBEEF, 32'h00002233, 32'h200};
    vecs[7]  = '{0, 1, 3'b010, 32'h202, 32'h11111111, 0, 0, 32'h0,        1, 1, 0, 0, 0, 4'h0, 32'h0,        32'h00002233, 32'h0};
    vecs[8]  = '{1, 0, 3'b001, 32'h101, 32'h0,        0, 1, 32'h0,        1, 1, 0, 0, 0, 4'h0, 32'h0,        32'h00002233, 32'h0};
    vecs[9]  = '{1, 0, 3'b011, 32'h100, 32'h0,        0, 1, 32'h0,        1, 1, 0, 0, 0, 4'h0, 32'h0,        32'h00002233, 32'h0};
    vecs[10] = '{0, 1, 3'b100, 32'h0,   32'h55,       0, 0, 32'h0,        1, 1, 0, 0, 0, 4'h0, 32'h0,        32'h00002233, 32'h0};
    vecs[11] = '{1, 0, 3'b010, 32'h300, 32'h0,        0, 0, 32'h0,        5, 0, 1, 1, 0, 4'h0, 32'h0,        32'h0,        32'h300};
    vecs[12] = '{1, 0, 3'b010, 32'h104, 32'h0,        0, 1, 32'h12345678, 3, 0, 0, 1, 0, 4'h0, 32'h0,        32'h12345678, 32'h104};
    vecs[13] = '{1, 0, 3'b000, 32'h100, 32'h0,        0, 1, 32'h0000007F, 3, 0, 0, 1, 0, 4'h0, 32'h0,        32'h0000007F, 32'h100};
    vecs[14] = '{1, 0, 3'b010, 32'h400, 32'h0,        99, 0, 32'h0,       5, 0, 1, 1, 0, 4'h0, 32'h0,        32'h0,        32'h400};
    vecs[15] = '{0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 0, 0, 32'h0,        2, 0, 0, 1, 1, 4'hF, 32'hCAFEF00D, 32'h0,        32'h400};
    vecs[16] = '{1, 0, 3'b001, 32'h100, 32'h0,        2, 1, 32'h0000F00D, 5, 0, 0, 1, 0, 4'h0, 32'h0,        32'hFFFFF00D, 32'h100};

    rst_n = 1'b0; lsu_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_ready", 32'(lsu_ready), 32'h1);
    check("rst_outs", {26'h0, mem_we, done, fault, bus_error, stall, 1'b0}, 32'h0);
    check("rst_bus", mem_addr | mem_wdata | 32'(mem_wmask) | data_mem_out, 32'h0);
    rst_n = 1'b1;

    // Neither or both type bits: never accepted.
    @(negedge clk);
    lsu_valid = 1'b1; is_load = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("both_no_req", {30'h0, mem_req, stall}, 32'h0);
      check("both_ready", 32'(lsu_ready), 32'h1);
    end
    is_load = 1'b0; is_store = 1'b0;
    @(negedge clk);
    check("none_no_req", {30'h0, mem_req, stall}, 32'h0);
    lsu_valid = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      v = vecs[i];
      @(negedge clk);
      check($sformatf("v%0d_ready", i), {30'h0, lsu_ready, stall}, 32'h2);
      lsu_valid = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
      addr = v.addr; store_data = v.sd;
      @(negedge clk);
      lsu_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; addr = 32'hFFFF_FFFF;
      store_data = 32'h0;
      cyc = 1; req_cycles = 0; got_done = 1'b0; stable_bad = 1'b0; stall_bad = 1'b0;
      lat = 0; got_flt = 1'b0; got_be = 1'b0; got_dout = 32'h0;
      cap_addr = 32'h0; cap_wdata = 32'h0; cap_we = 1'b0; cap_mask = 4'h0;
      while (!got_done && cyc < 20) begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hBAD0BAD0;
        if (done) begin
          got_done = 1'b1; lat = cyc; got_flt = fault; got_be = bus_error;
          got_dout = data_mem_out;
        end else begin
          if (mem_req) begin
            if (req_cycles == 0) begin
              cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we; cap_mask = mem_wmask;
            end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                         mem_we !== cap_we || mem_wmask !== cap_mask) begin
              stable_bad = 1'b1;
            end
            if (!stall) stall_bad = 1'b1;
            if (req_cycles == v.gnt_dly) mem_gnt = 1'b1;
            if (v.ld) mem_rvalid = 1'b1;  // early rvalid must be ignored
            req_cycles++;
          end else if (stall && v.rv) begin
            mem_rvalid = 1'b1; mem_rdata = v.rdata;
          end
          @(negedge clk);
          cyc++;
        end
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!got_done) begin
        check($sformatf("v%0d_done_seen", i), 32'h0, 32'h1);
      end else begin
        check($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
        check($sformatf("v%0d_fault", i), 32'(got_flt), 32'(v.flt));
        check($sformatf("v%0d_bus_error", i), 32'(got_be), 32'(v.be));
        check($sformatf("v%0d_dout", i), got_dout, v.dout);
        check($sformatf("v%0d_req_seen", i), 32'(req_cycles != 0), 32'(v.req));
        check($sformatf("v%0d_stable", i), {30'h0, stable_bad, stall_bad}, 32'h0);
        if (v.req) begin
          check($sformatf("v%0d_addr", i), cap_addr, v.maddr);
          check($sformatf("v%0d_we", i), 32'(cap_we), 32'(v.we));
          check($sformatf("v%0d_mask", i), 32'(cap_mask), 32'(v.mask));
          if (v.we) check($sformatf("v%0d_wdata", i), cap_wdata, v.wdata);
        end
      end
    end

    // Async reset while waiting for read data; late rvalid must be ignored.
    @(negedge clk);
    lsu_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    lsu_valid = 1'b0; is_load = 1'b0;
    check("rw_req", 32'(mem_req), 32'h1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rw_in_wait", {30'h0, mem_req, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rw_rst_outs", {26'h0, mem_req, mem_we, done, fault, bus_error, stall}, 32'h0);
    check("rw_rst_ready", 32'(lsu_ready), 32'h1);
    check("rw_rst_dout", data_mem_out, 32'h0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rw_post_done", {30'h0, done, mem_req}, 32'h0);
      check("rw_post_dout", data_mem_out, 32'h0);
      check("rw_post_ready", 32'(lsu_ready), 32'h1);
    end
    mem_rvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
